// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one block RAM (write port a, read port b) among NREQ requesters.
// Optional macro RAM_ARB_FETCH_PRIO_EN: requester 0 wins every other arbitration.
module ram_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 10,
  parameter int DW   = 16
) (
  input  logic                 clka,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 ena,
  output logic                 wea,
  output logic [AW-1:0]        addra,
  output logic [DW-1:0]        dia,
  output logic                 enb,
  output logic [AW-1:0]        addrb,
  input  logic [DW-1:0]        dob
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DATA, WR} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic          found;
  int            idx;

`ifdef RAM_ARB_FETCH_PRIO_EN
  logic [IW-1:0] last_oth;

  // Fetch wins unless it held the previous grant; others rotate on their own pointer.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    if (req[0] && last != '0) begin
      found = 1'b1;
    end else begin
      for (int k = 1; k < NREQ; k++) begin
        idx = ((int'(last_oth) - 1 + k) % (NREQ - 1)) + 1;
        if (!found && req[idx]) begin
          found = 1'b1;
          win   = IW'(idx);
        end
      end
      if (!found && req[0]) begin
        found = 1'b1;
        win   = '0;
      end
    end
  end
`else
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end
`endif

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      rvalid <= '0;
      rdata  <= '0;
      ena    <= 1'b0;
      wea    <= 1'b0;
      enb    <= 1'b0;
      addra  <= '0;
      addrb  <= '0;
      dia    <= '0;
      last   <= IW'(NREQ - 1);
`ifdef RAM_ARB_FETCH_PRIO_EN
      last_oth <= IW'(NREQ - 1);
`endif
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt[win] <= 1'b1;
            last     <= win;
`ifdef RAM_ARB_FETCH_PRIO_EN
            if (win != '0) last_oth <= win;
`endif
            if (we[win]) begin
              ena   <= 1'b1;
              wea   <= 1'b1;
              addra <= addr[win*AW +: AW];
              dia   <= wdata[win*DW +: DW];
              state <= WR;
            end else begin
              enb   <= 1'b1;
              addrb <= addr[win*AW +: AW];
              state <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          enb   <= 1'b0;
          state <= RD_DATA;
        end
        // dob was latched by the RAM on the previous edge; last still names the reader
        RD_DATA: begin
          rdata        <= dob;
          rvalid[last] <= 1'b1;
          state        <= IDLE;
        end
        WR: begin
          ena   <= 1'b0;
          wea   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: transaction-level arbitration/memory model feeds
// expected grants and read returns into queues checked by a negedge monitor.
module tb_ram_port_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int DW   = 16;

  logic                clka = 1'b0;
  logic                rst  = 1'b1;
  logic [NREQ-1:0]     req  = '0;
  logic [NREQ-1:0]     we   = '0;
  logic [NREQ*AW-1:0]  addr = '0;
  logic [NREQ*DW-1:0]  wdata = '0;
  logic [NREQ-1:0]     gnt, rvalid;
  logic [DW-1:0]       rdata, dia, dob;
  logic                ena, wea, enb;
  logic [AW-1:0]       addra, addrb;

  ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clka(clka), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ena(ena), .wea(wea),
    .addra(addra), .dia(dia), .enb(enb), .addrb(addrb), .dob(dob)
  );

  always #5 clka = ~clka;

  // Block RAM attached to the arbiter
  logic [DW-1:0] ram  [0:(1<<AW)-1];
  logic [DW-1:0] mmem [0:(1<<AW)-1];
  always @(posedge clka) begin
    if (ena && wea) ram[addra] <= dia;
    if (enb) dob <= ram[addrb];
  end

  typedef struct { int w; bit wr; logic [AW-1:0] a; logic [DW-1:0] d; } gexp_t;
  typedef struct { int w; logic [DW-1:0] d; int due; } rexp_t;

  gexp_t exp_g[$];
  rexp_t exp_r[$];
  int    glog[$];
  int    n_chk = 0, n_fail = 0, cyc = 0;
  int    m_last = NREQ - 1, m_oth = NREQ - 1, cool = 0, mw;
  gexp_t mg, mg2;
  rexp_t mr, mr2;
  logic [DW-1:0] m_rdata = '0;
  int    hold [NREQ];
  bit    auto_re [NREQ];
  bit    rand_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
`ifdef RAM_ARB_FETCH_PRIO_EN
    if (r[0] && m_last != 0) return 0;
    for (int k = 1; k < NREQ; k++) begin
      int j;
      j = ((m_oth - 1 + k) % (NREQ - 1)) + 1;
      if (r[j]) return j;
    end
    return 0;
`else
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (m_last + k) % NREQ;
      if (r[j]) return j;
    end
    return 0;
`endif
  endfunction

  // Reference model: one transaction at a time, read busy 3 cycles, write 2
  always @(posedge clka) begin
    cyc = cyc + 1;
    if (rst) begin
      m_last = NREQ - 1;
      m_oth  = NREQ - 1;
      cool   = 0;
      exp_g.delete();
      exp_r.delete();
    end else if (cool > 0) begin
      cool = cool - 1;
    end else if (req != '0) begin
      mw   = pick(req);
      mg.w = mw;
      mg.wr = we[mw];
      mg.a = addr[mw*AW +: AW];
      mg.d = wdata[mw*DW +: DW];
      exp_g.push_back(mg);
      if (mg.wr) begin
        mmem[mg.a] = mg.d;
        cool = 1;
      end else begin
        mr.w = mw;
        mr.d = mmem[mg.a];
        mr.due = cyc + 2;
        exp_r.push_back(mr);
        cool = 2;
      end
      m_last = mw;
      if (mw != 0) m_oth = mw;
    end
  end

  always @(negedge clka) begin
    if (rst) begin
      check("reset_outputs", {gnt, rvalid, rdata, ena, wea, enb, addra, addrb, dia}, '0);
      m_rdata = '0;
    end else begin
      if (exp_g.size() > 0) begin
        mg2 = exp_g.pop_front();
        check("gnt", gnt, 1 << mg2.w);
        if (mg2.wr) check("wr_port", {ena, wea, enb, addra, dia}, {3'b110, mg2.a, mg2.d});
        else        check("rd_port", {ena, wea, enb, addrb}, {3'b001, mg2.a});
        for (int i = 0; i < NREQ; i++) if (gnt[i]) glog.push_back(i);
      end else begin
        check("idle_pulses", {gnt, ena, wea, enb}, '0);
      end
      if (exp_r.size() > 0 && exp_r[0].due == cyc) begin
        mr2 = exp_r.pop_front();
        check("rvalid", rvalid, 1 << mr2.w);
        check("rdata", rdata, mr2.d);
        m_rdata = mr2.d;
      end else begin
        check("rvalid_idle", rvalid, '0);
        check("rdata_hold", rdata, m_rdata);
      end
    end
  end

  task automatic raise(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic step();
    logic [AW-1:0] ra;
    @(posedge clka);
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && gnt[i]) begin
        req[i]  = 1'b0;
        hold[i] = 0;
      end else if (req[i]) begin
        hold[i]++;
        if (hold[i] > 100) begin
          n_fail++;
          $display("FAIL req_timeout: requester %0d waited %0d cycles, limit 100", i, hold[i]);
          req[i]  = 1'b0;
          hold[i] = 0;
        end
      end else if (auto_re[i]) begin
        raise(i, 1'b0, AW'(16 + i), '0);
      end else if (rand_en && $urandom_range(0, 2) == 0) begin
        ra = ($urandom_range(0, 7) == 0) ? {AW{1'b1}} : AW'($urandom_range(0, 15));
        raise(i, 1'($urandom_range(0, 1)), ra, DW'($urandom));
      end
    end
  endtask

  task automatic wait_gnt(input int i);
    int n = 0;
    do begin step(); n++; end while (!gnt[i] && n < 30);
    check("gnt_seen", gnt[i], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int exp4 [6];
  int n;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]  = DW'(i * 257) ^ 16'h5A5A;
      mmem[i] = DW'(i * 257) ^ 16'h5A5A;
    end
    ram[5]  = 16'h1234;
    mmem[5] = 16'h1234;
    for (int i = 0; i < NREQ; i++) begin hold[i] = 0; auto_re[i] = 1'b0; end

    repeat (3) step();
    rst = 1'b0;
    check("reset_state", {gnt, rvalid, rdata}, '0);

    // Single read, latency gnt -> rvalid of two cycles
    raise(1, 1'b0, 10'd5, '0);
    wait_gnt(1);
    step();
    step();
    check("t1_rvalid", rvalid, 4'b0010);
    check("t1_rdata", rdata, 16'h1234);
    step();

    // Write then read back the same address
    raise(2, 1'b1, 10'd7, 16'hBEEF);
    wait_gnt(2);
    check("t3_wea_on", {ena, wea}, 2'b11);
    step();
    check("t3_wea_off", {ena, wea}, 2'b00);
    raise(0, 1'b0, 10'd7, '0);
    wait_gnt(0);
    step();
    step();
    check("t3_rvalid", rvalid, 4'b0001);
    check("t3_rdata", rdata, 16'hBEEF);

    // All four requesters read at once
    do_reset();
    glog.delete();
    for (int i = 0; i < NREQ; i++) raise(i, 1'b0, AW'(32 + i), '0);
    repeat (16) step();
    check("t2_count", glog.size(), 4);
    for (int k = 0; k < 4; k++) if (k < glog.size()) check("t2_order", glog[k], k);

    // Requesters 0..2 held continuously
    do_reset();
    glog.delete();
`ifdef RAM_ARB_FETCH_PRIO_EN
    exp4 = '{0, 1, 0, 2, 0, 1};
`else
    exp4 = '{0, 1, 2, 0, 1, 2};
`endif
    for (int i = 0; i < 3; i++) auto_re[i] = 1'b1;
    n = 0;
    while (glog.size() < 6 && n < 40) begin step(); n++; end
    for (int i = 0; i < 3; i++) auto_re[i] = 1'b0;
    check("t4_count_ge6", glog.size() >= 6, 1'b1);
    for (int k = 0; k < 6; k++) if (k < glog.size()) check("t4_order", glog[k], exp4[k]);
    repeat (12) step();

    // Reset during RD_DATA aborts the read; 0 wins afterwards
    do_reset();
    raise(2, 1'b0, 10'd9, '0);
    wait_gnt(2);
    step();
    rst = 1'b1;
    raise(0, 1'b0, 10'd3, '0);
    raise(2, 1'b0, 10'd4, '0);
    #1;
    check("t5_abort", {gnt, rvalid, ena, enb, wea}, '0);
    step();
    step();
    rst = 1'b0;
    n = 0;
    do begin step(); n++; end while (gnt == '0 && n < 30);
    check("t5_first_gnt", gnt, 4'b0001);
    repeat (10) step();

    // Quiet bus: nothing pulses, rdata holds
    for (int k = 0; k < 10; k++) begin
      step();
      check("t6_idle", {gnt, rvalid, ena, enb, wea}, '0);
      check("t6_rdata_hold", rdata, m_rdata);
    end

    // Randomized traffic
    rand_en = 1'b1;
    repeat (400) step();
    rand_en = 1'b0;
    repeat (30) step();
    check("queues_drained", exp_g.size() + exp_r.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
